// File: rtl/arbitro_multiplicador.sv
// Shares one external combinational 4x4 multiplier between two requesters (round-robin by default).
// Define ARBITRO_PRIO_FIXA_EN for fixed priority: requester 0 always wins a tie.
module arbitro_multiplicador #(
    parameter int unsigned MULT_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic [7:0] mul_p,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_p,
    output logic       busy
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned P_W   = 8;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             grant0_c;
    logic             grant1_c;
    logic             accept_c;

`ifdef ARBITRO_PRIO_FIXA_EN
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        grant0_c = req0_valid;
        grant1_c = req1_valid && !req0_valid;
    end
`else
    logic prio;

    // Round-robin: a lone requester wins; on a tie, prio names the winner.
    always_comb begin
        grant0_c = req0_valid && (!req1_valid || !prio);
        grant1_c = req1_valid && (!req0_valid || prio);
    end

    // After an accept, favour the requester that was not granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (accept_c) begin
            prio <= req0_ready;
        end
    end
`endif

    // Grants are visible only in IDLE and never while reset is asserted.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && state == IDLE) begin
            req0_ready = grant0_c;
            req1_ready = grant1_c;
        end
    end

    assign accept_c = req0_ready || req1_ready;

    // Main control: accept operands, hold them MULT_LAT cycles, return the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_p     <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        mul_a  <= req0_ready ? req0_a : req1_a;
                        mul_b  <= req0_ready ? req0_b : req1_b;
                        rsp_id <= req1_ready;
                        cnt    <= CNT_LOAD;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rsp_p     <= mul_p;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Operand and product widths are fixed by the external multiplier.
    if (OP_W != 4 || P_W != 8) begin : g_width_guard
        logic unused_width_guard;
        assign unused_width_guard = 1'b0;
    end

endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Directed scoreboard bench: one instance with MULT_LAT=1 and one with MULT_LAT=3, selected by sel.
module tb_arbitro_multiplicador;

    typedef struct packed {
        logic       id;
        logic [7:0] p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       v0, v1, rdy;
    logic [3:0] a0, b0, a1, b1;

    logic       a_r0, a_r1, a_rv, a_rid, a_busy;
    logic [3:0] a_ma, a_mb;
    logic [7:0] a_mp, a_rp;
    logic       b_r0, b_r1, b_rv, b_rid, b_busy;
    logic [3:0] b_ma, b_mb;
    logic [7:0] b_mp, b_rp;

    logic       o_r0, o_r1, o_rv, o_rid, o_busy;
    logic [3:0] o_ma, o_mb;
    logic [7:0] o_rp;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // External shared multipliers (one per instance).
    assign a_mp = 8'(a_ma) * 8'(a_mb);
    assign b_mp = 8'(b_ma) * 8'(b_mb);

    arbitro_multiplicador #(.MULT_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0 && !sel), .req0_a(a0), .req0_b(b0), .req0_ready(a_r0),
        .req1_valid(v1 && !sel), .req1_a(a1), .req1_b(b1), .req1_ready(a_r1),
        .mul_a(a_ma), .mul_b(a_mb), .mul_p(a_mp),
        .rsp_valid(a_rv), .rsp_ready(rdy && !sel), .rsp_id(a_rid), .rsp_p(a_rp),
        .busy(a_busy)
    );

    arbitro_multiplicador #(.MULT_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req0_valid(v0 && sel), .req0_a(a0), .req0_b(b0), .req0_ready(b_r0),
        .req1_valid(v1 && sel), .req1_a(a1), .req1_b(b1), .req1_ready(b_r1),
        .mul_a(b_ma), .mul_b(b_mb), .mul_p(b_mp),
        .rsp_valid(b_rv), .rsp_ready(rdy && sel), .rsp_id(b_rid), .rsp_p(b_rp),
        .busy(b_busy)
    );

    assign o_r0   = sel ? b_r0   : a_r0;
    assign o_r1   = sel ? b_r1   : a_r1;
    assign o_rv   = sel ? b_rv   : a_rv;
    assign o_rid  = sel ? b_rid  : a_rid;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_ma   = sel ? b_ma   : a_ma;
    assign o_mb   = sel ? b_mb   : a_mb;
    assign o_rp   = sel ? b_rp   : a_rp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Count edges until rsp_valid is seen; exp_lat of 0 skips the latency compare.
    task automatic wait_valid(input int exp_lat);
        int n = 0;
        while (o_rv !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rsp_seen", 32'(o_rv), 1);
        if (exp_lat > 0) check("latency", 32'(n), 32'(exp_lat));
    endtask

    // Pop the expected response, compare, then complete the handshake.
    task automatic finish_rsp(input logic keep_ready);
        exp_t e;
        check("sb_has_entry", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("rsp_id", 32'(o_rid), 32'(e.id));
            check("rsp_p", 32'(o_rp), 32'(e.p));
        end
        rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy = keep_ready;
        #1;
        check("rsp_dropped", 32'(o_rv), 0);
        check("idle_busy", 32'(o_busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sel = 1'b0; v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);

        // Reset values; readys must stay low while rst is high even with valid requests.
        v0 = 1'b1; v1 = 1'b1;
        #1;
        check("rst_r0", 32'(o_r0), 0);
        check("rst_r1", 32'(o_r1), 0);
        check("rst_mul_a", 32'(o_ma), 0);
        check("rst_mul_b", 32'(o_mb), 0);
        check("rst_rsp_valid", 32'(o_rv), 0);
        check("rst_rsp_id", 32'(o_rid), 0);
        check("rst_rsp_p", 32'(o_rp), 0);
        check("rst_busy", 32'(o_busy), 0);
        sel = 1'b1;
        #1;
        check("rst_b_r1", 32'(o_r1), 0);
        check("rst_b_busy", 32'(o_busy), 0);
        sel = 1'b0; v0 = 1'b0; v1 = 1'b0; rst = 1'b0;

        // Single request 3*5.
        @(negedge clk);
        a0 = 4'd3; b0 = 4'd5; v0 = 1'b1;
        #1;
        check("t1_r0", 32'(o_r0), 1);
        check("t1_r1", 32'(o_r1), 0);
        q.push_back({1'b0, 8'd15});
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        check("t1_busy", 32'(o_busy), 1);
        check("t1_mul_a", 32'(o_ma), 3);
        check("t1_mul_b", 32'(o_mb), 5);
        wait_valid(1);
        finish_rsp(1'b0);

        // Both valid right after reset: requester 0 first, then requester 1.
        do_reset();
        a0 = 4'd15; b0 = 4'd15; a1 = 4'd2; b1 = 4'd7; v0 = 1'b1; v1 = 1'b1;
        #1;
        check("t2_r0", 32'(o_r0), 1);
        check("t2_r1", 32'(o_r1), 0);
        q.push_back({1'b0, 8'd225});
        q.push_back({1'b1, 8'd14});
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        check("t2_r1_busy", 32'(o_r1), 0);
        wait_valid(1);
        finish_rsp(1'b0);
        check("t2_r1_grant", 32'(o_r1), 1);
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        #1;
        check("t2_mul_a", 32'(o_ma), 2);
        check("t2_mul_b", 32'(o_mb), 7);
        wait_valid(1);
        finish_rsp(1'b0);

        // Backpressure: response held 5 cycles while requester 0 waits.
        a1 = 4'd6; b1 = 4'd7; v1 = 1'b1;
        #1;
        q.push_back({1'b1, 8'd42});
        q.push_back({1'b0, 8'd1});
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0; a0 = 4'd1; b0 = 4'd1; v0 = 1'b1;
        #1;
        wait_valid(1);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(o_rv), 1);
            check("bp_p", 32'(o_rp), 42);
            check("bp_id", 32'(o_rid), 1);
            check("bp_mul_a", 32'(o_ma), 6);
            check("bp_mul_b", 32'(o_mb), 7);
            check("bp_r0", 32'(o_r0), 0);
            check("bp_r1", 32'(o_r1), 0);
            @(negedge clk);
            #1;
        end
        finish_rsp(1'b0);
        check("bp_next_r0", 32'(o_r0), 1);
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        wait_valid(1);
        finish_rsp(1'b0);

        // Fairness with both requesters held valid and rsp_ready held high.
        do_reset();
        a0 = 4'd2; b0 = 4'd3; a1 = 4'd4; b1 = 4'd5; v0 = 1'b1; v1 = 1'b1; rdy = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARBITRO_PRIO_FIXA_EN
            q.push_back({1'b0, 8'd6});
`else
            if (k % 2 == 0) q.push_back({1'b0, 8'd6});
            else            q.push_back({1'b1, 8'd20});
`endif
        end
        for (int k = 0; k < 4; k++) begin
            wait_valid(2);
            finish_rsp(1'b1);
        end
        v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;
        @(negedge clk);

        // Latency on the MULT_LAT=3 instance: 9*9.
        sel = 1'b1;
        a1 = 4'd9; b1 = 4'd9; v1 = 1'b1;
        #1;
        check("t5_r1", 32'(o_r1), 1);
        q.push_back({1'b1, 8'd81});
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        #1;
        check("t5_busy", 32'(o_busy), 1);
        check("t5_mul_a", 32'(o_ma), 9);
        wait_valid(3);
        finish_rsp(1'b0);

        // Reset on the second CALC cycle abandons the transaction.
        a1 = 4'd5; b1 = 4'd5; v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("t6_r1", 32'(o_r1), 0);
        check("t6_rsp_valid", 32'(o_rv), 0);
        check("t6_rsp_p", 32'(o_rp), 0);
        check("t6_rsp_id", 32'(o_rid), 0);
        check("t6_mul_a", 32'(o_ma), 0);
        check("t6_mul_b", 32'(o_mb), 0);
        check("t6_busy", 32'(o_busy), 0);
        rst = 1'b0; v1 = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("t6_no_rsp", 32'(o_rv), 0);
        check("sb_drained", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
